// File: rtl/stream_mux_arb_pkg.sv
// Shared types and helpers for the stream_mux_arb channel merger.
// Build option STREAM_MUX_ARB_SKID_EN is consumed by the top level only.
package stream_mux_arb_pkg;

  typedef enum logic [0:0] {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// One-hot arbiter over N requesters: fixed lowest-index priority or
// round-robin with a rotating priority pointer that moves only on transfers.
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int    N    = 4,
  parameter mode_e MODE = MODE_RR,
  localparam int   SW   = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr_r;
  logic [SW-1:0] next_ptr_s;

  // Walk the channels starting at the pointer; the first requester wins.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {SW{1'b0}};
    for (int k = 0; k < N; k++) begin
      int   cand;
      logic hit;
      cand        = (MODE == MODE_RR) ? ((int'(ptr_r) + k) % N) : k;
      hit         = req[cand] && (grant == {N{1'b0}});
      grant[cand] = hit;
      grant_idx   = hit ? SW'(cand) : grant_idx;
    end
  end

  assign next_ptr_s = (grant_idx == SW'(N - 1)) ? {SW{1'b0}} : (grant_idx + SW'(1));

  // Rotate priority past the channel that just transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {SW{1'b0}};
    end else if (advance && (MODE == MODE_RR)) begin
      ptr_r <= next_ptr_s;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N:1 valid/ready stream merger tagging each word with its source.
// Define STREAM_MUX_ARB_SKID_EN to add a skid register and cut in_ready from out_ready.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int    N    = 4,
  parameter int    W    = 8,
  parameter mode_e MODE = MODE_RR,
  localparam int   SW   = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [N-1:0]  grant_s;
  logic [SW-1:0] grant_idx_s;
  logic          can_load_s;
  logic          accept_s;
  logic [W-1:0]  mux_data_s;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_sel_r;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (accept_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign in_ready   = rst ? {N{1'b0}} : (grant_s & {N{can_load_s}});
  assign accept_s   = |in_ready;
  assign mux_data_s = in_data[int'(grant_idx_s) * W +: W];

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_sel    = out_sel_r;

`ifdef STREAM_MUX_ARB_SKID_EN
  logic          skid_valid_r;
  logic [W-1:0]  skid_data_r;
  logic [SW-1:0] skid_sel_r;
  logic          out_free_s;

  // Skid occupancy is registered, so acceptance never waits on out_ready.
  assign can_load_s = !skid_valid_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Output stage refills from skid first to keep acceptance order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {W{1'b0}};
      out_sel_r    <= {SW{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      skid_sel_r   <= {SW{1'b0}};
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_data_r   <= skid_data_r;
        out_sel_r    <= skid_sel_r;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_valid_r  <= 1'b1;
        out_data_r   <= mux_data_s;
        out_sel_r    <= grant_idx_s;
      end else begin
        out_valid_r  <= 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= mux_data_s;
      skid_sel_r   <= grant_idx_s;
    end
  end
`else
  assign can_load_s = !out_valid_r || out_ready;

  // Load on accept; otherwise empty once the consumer takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_sel_r   <= {SW{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mux_data_s;
      out_sel_r   <= grant_idx_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: a round-robin and a fixed-priority instance share
// directed stimulus; a queue-level model checks both every cycle.
module tb_stream_mux_arb;
  import stream_mux_arb_pkg::*;

`ifdef STREAM_MUX_ARB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int DEPTH = SKID ? 2 : 1;

  logic            clk;
  logic            rst;
  logic [3:0]      iv;
  logic [31:0]     idat;
  logic            ordy;
  logic [1:0][3:0] ir;
  logic [1:0]      ov;
  logic [1:0][7:0] od;
  logic [1:0][1:0] os;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // model state: per instance buffered words (oldest first) and RR pointer
  int         cnt [2];
  logic [7:0] bd  [2][2];
  logic [1:0] bs  [2][2];
  int         ptr [2];

  stream_mux_arb #(.N(4), .W(8), .MODE(MODE_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(iv), .in_data(idat), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(ordy)
  );

  stream_mux_arb #(.N(4), .W(8), .MODE(MODE_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(iv), .in_data(idat), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference: check outputs, then apply this cycle's transfers.
  task automatic model_cycle(input int m);
    int         g;
    bit         cl;
    bit         eov;
    logic [3:0] eir;
    string      p;
    p = (m == 0) ? "rr" : "fx";
    g = -1;
    for (int o = 0; o < 4; o++) begin
      int c;
      c = (m == 0) ? ((ptr[m] + o) % 4) : o;
      if (g < 0 && iv[c]) g = c;
    end
    eov = (cnt[m] > 0);
    cl  = SKID ? (cnt[m] < 2) : (cnt[m] == 0 || ordy);
    eir = (!rst && cl && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk({p, ".out_valid"}, 32'(ov[m]), 32'(eov));
    chk({p, ".in_ready"}, 32'(ir[m]), 32'(eir));
    if (eov) begin
      chk({p, ".out_data"}, 32'(od[m]), 32'(bd[m][0]));
      chk({p, ".out_sel"}, 32'(os[m]), 32'(bs[m][0]));
    end
    if (rst) begin
      cnt[m] = 0;
      ptr[m] = 0;
    end else begin
      if (eov && ordy) begin
        bd[m][0] = bd[m][1];
        bs[m][0] = bs[m][1];
        cnt[m]--;
      end
      if (eir != 4'b0000) begin
        bd[m][cnt[m]] = idat[g*8 +: 8];
        bs[m][cnt[m]] = g[1:0];
        cnt[m]++;
        if (m == 0) ptr[m] = (g + 1) % 4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_cycle(0);
      model_cycle(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_lit();
    for (int m = 0; m < 2; m++) begin
      chk("reset out_valid", 32'(ov[m]), 32'd0);
      chk("reset out_data", 32'(od[m]), 32'd0);
      chk("reset out_sel", 32'(os[m]), 32'd0);
      chk("reset in_ready", 32'(ir[m]), 32'd0);
    end
  endtask

  initial begin
    int acc;
    int outs;
    logic [3:0] first;
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      ptr[m] = 0;
    end
    rst  = 1'b1;
    iv   = 4'hF;
    idat = 32'hA3A2A1A0;
    ordy = 1'b1;
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    reset_lit();
    @(posedge clk);
    @(negedge clk);
    reset_lit();
    step();
    rst = 1'b0;

    // round-robin fairness: all channels valid, consumer always ready
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr seq data", 32'(od[0]), 32'hA0 + 32'(k % 4));
      chk("rr seq sel", 32'(os[0]), 32'(k % 4));
      chk("fx seq sel", 32'(os[1]), 32'd0);
    end

    // fixed priority: channels 1 and 3
    step();
    iv = 4'b1010;
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fx only ch1", 32'(os[1]), 32'd1);
      chk("fx ch3 starved", 32'(ir[1][3]), 32'd0);
    end
    step();
    iv = 4'b1000;
    @(negedge clk);
    chk("fx ch3 granted", 32'(ir[1]), 32'b1000);
    @(negedge clk);
    chk("fx ch3 out", 32'(os[1]), 32'd3);

    // backpressure on channel 2
    step();
    iv = 4'b0000;
    step();
    step();
    iv = 4'b0100;
    idat[23:16] = 8'h5C;
    ordy = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ir[0][2]) acc++;
      if (k > 0) begin
        chk("bp hold data", 32'(od[0]), 32'h5C);
        chk("bp hold sel", 32'(os[0]), 32'd2);
      end
    end
    chk("bp accepted", 32'(acc), 32'(DEPTH));
    step();
    iv = 4'b0000;
    ordy = 1'b1;
    outs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov[0]) outs++;
    end
    chk("bp drained", 32'(outs), 32'(DEPTH));

    // wrap to ptr 0 via channel 3, then hold while 0 and 2 wait
    step();
    iv = 4'b1000;
    ordy = 1'b0;
    repeat (DEPTH) step();
    iv = 4'b0101;
    repeat (3) begin
      @(negedge clk);
      chk("wrap stall", 32'(ir[0]), 32'd0);
    end
    step();
    ordy = 1'b1;
    first = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (first == 4'b0000 && ir[0] != 4'b0000) first = ir[0];
    end
    chk("wrap first grant", 32'(first), 32'b0001);

    // reset with words buffered
    step();
    iv = 4'b0000;
    repeat (3) step();
    iv = 4'b0010;
    idat[15:8] = 8'h77;
    ordy = 1'b0;
    repeat (DEPTH) step();
    iv = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst no emit", 32'(ov[0]), 32'd0);
    end
    step();
    iv = 4'b1111;
    @(negedge clk);
    chk("midrst ptr0", 32'(ir[0]), 32'b0001);

    step();
    iv = 4'b0000;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Registered N-channel multiplexer with built-in arbitration. It is the sequential, parametrised successor of the 2:1 combinational mux. It merges N valid/ready input streams of W-bit data into one output stream, tagging each word with its source channel. It sits between independent producers and a single shared consumer, for example a shared bus port or a single FIFO write port.

## Interface
- `N`, default 4: number of input channels; legal values ≥ 1.
- `W`, default 8: data width in bits; legal values ≥ 1.
- `MODE`, default `MODE_RR`: arbitration mode.
  - `MODE_RR`: round-robin.
  - `MODE_FIXED`: fixed priority, lowest index wins.
- `SW`, derived (not overridable): `N == 1 ? 1 : $clog2(N)`.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input N: per-channel valid.
- `in_data` input N*W: flattened data; channel i is `in_data[i*W +: W]`.
- `in_ready` output N: per-channel ready; at most one bit high per cycle.
- `out_valid` output 1: output word valid.
- `out_data` output W: output word.
- `out_sel` output SW: source channel index of `out_data`.
- `out_ready` input 1: consumer ready.

## Operation
- Input transfer on channel i: `in_valid[i] && in_ready[i]` in the same cycle.
- Output transfer: `out_valid && out_ready`.
- Each cycle the arbiter computes a one-hot `grant` from `in_valid`.
  - `grant` is all-zero when no input is valid.
  - `in_ready[i] = grant[i] && can_load`. `can_load` is defined under Configuration.
- `MODE_FIXED`: grant goes to the lowest-index valid channel.
- `MODE_RR`:
  - A priority pointer `ptr` (SW bits) marks the highest-priority channel.
  - Search order is ptr, ptr+1, …, wrapping mod N.
  - After an input transfer from channel g, `ptr` becomes `(g+1) mod N`. Wrap: g = N−1 gives ptr = 0.
  - `ptr` is unchanged on cycles with no input transfer.
  - A grant offered but not taken (`can_load` low) does not move `ptr`.
- `grant` depends only on `in_valid` and `ptr`; it never depends on `in_data`.
- The arbiter must not drop a granted word once it has been transferred.
- Words leave the block in the same order they were accepted.
- While `out_valid && !out_ready`, `out_data` and `out_sel` hold stable.
- `N == 1`: channel 0 is always granted when valid; `out_sel` is constantly 0.

Reset values (after `rst` is sampled high):
- `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
- `in_ready` is driven low while `rst` is high.

Reset mid-operation: all buffered words are discarded. No transfer occurs in a cycle where `rst` is high.

## Timing
- Latency: an input accepted in cycle t appears with `out_valid` = 1 in cycle t+1.
- Throughput: 1 word per cycle while `out_ready` is held high.
- Simultaneous output transfer and new input acceptance in the same cycle is required; there must be no bubble.
- All outputs except `in_ready` are driven directly from flops.

## Configuration
`STREAM_MUX_ARB_SKID_EN`:
- Undefined (default):
  - One output register.
  - `can_load = !out_valid || out_ready`.
  - `in_ready` has a combinational path from `out_ready`.
- Defined:
  - A second (skid) register is added; the block holds up to 2 words.
  - `can_load = !skid_full`, a registered signal.
  - `in_ready` has no combinational path from `out_ready`.
  - When the output register is occupied and `out_ready` is low, an accepted word goes to the skid register.
  - The skid word moves to the output register on the next output transfer.
  - Ordering and latency (1 cycle when empty) are unchanged.
  - Sustained throughput stays 1 word/cycle.

## Structure
- Package `stream_mux_arb_pkg`:
  - enum `mode_e` with values `MODE_FIXED`, `MODE_RR`.
  - Shared helper function returning `SW` for a given N.
- Sub-module `rr_arbiter`:
  - Parameters `N`, `MODE`.
  - Inputs: `clk`, `rst`, `req[N]`, `advance`, where `advance` = input transfer occurred.
  - Outputs: `grant[N]` (one-hot), `grant_idx[SW]`.
  - Owns `ptr`.
- The top level owns the output/skid registers and the data mux, selected by `grant_idx`.

## Test plan
- Reset: drive `rst` = 1 for 2 cycles with all `in_valid` high. Expect `out_valid` = 0, `out_data` = 0, `out_sel` = 0 and `in_ready` = 0 throughout.
- RR fairness: N=4, `MODE_RR`, all channels valid, data = 0xA0+i, `out_ready` = 1. Expect `out_sel` sequence 0,1,2,3,0,1… and `out_data` 0xA0,0xA1,0xA2,0xA3,… at 1 word/cycle, starting 1 cycle after the first accept.
- Fixed priority: `MODE_FIXED`, channels 1 and 3 continuously valid. Expect only `out_sel` = 1, and channel 3 never granted. Drop channel 1 valid: channel 3 granted the next cycle.
- Backpressure: hold `out_ready` = 0 for 5 cycles with channel 2 valid (0x5C).
  - Without skid: exactly 1 word accepted.
  - With skid: exactly 2 words accepted.
  - In both builds `out_data` holds at 0x5C with `out_sel` = 2 throughout, then the accepted words drain in order on release.
- Wrap/hold: grant channel 3 (ptr → 0), then stall `can_load` while channels 0 and 2 are valid. Expect ptr to stay 0, and channel 0 granted first on release.
- Mid-operation reset: with skid enabled, two words buffered, assert `rst` for 1 cycle. Expect `out_valid` = 0 the next cycle, neither buffered word ever emitted, and ptr = 0.
